// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the register-file write-back stage.
package writeback_stage_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 4;
    localparam int REG_COUNT = 2 ** ADDR_W;
    localparam int WB_DEPTH  = 4;

    // One pending register-file write
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bus bundle between the execute/memory paths, decode forwarding and the write-back stage.
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              wb_hold;
    logic              rf_enable;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] fwd_reg1;
    logic [ADDR_W-1:0] fwd_reg2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic              wb_empty;

    // Upstream side: offers results, hold and forwarding lookups
    modport master (
        output mem_valid, mem_reg, mem_data,
        output alu_valid, alu_reg, alu_data,
        output wb_hold, fwd_reg1, fwd_reg2,
        input  mem_ready, alu_ready,
        input  rf_enable, rf_write_reg, rf_write_data,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, wb_empty
    );

    // Write-back stage side
    modport slave (
        input  mem_valid, mem_reg, mem_data,
        input  alu_valid, alu_reg, alu_data,
        input  wb_hold, fwd_reg1, fwd_reg2,
        output mem_ready, alu_ready,
        output rf_enable, rf_write_reg, rf_write_data,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, wb_empty
    );
endinterface

// File: rtl/writeback_stage_wb_fifo.sv
// Pending-write FIFO: two pushes per cycle (push_a is older), one pop,
// and every slot exposed in parallel with its age for the forwarding search.
module wb_fifo
    import writeback_stage_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_a,
    input  wb_entry_t                   entry_a,
    input  logic                        push_b,
    input  wb_entry_t                   entry_b,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic [CNT_W-1:0]            count,
    output logic [DEPTH-1:0]            slot_valid,
    output logic [DEPTH-1:0][PTR_W-1:0] slot_age,
    output wb_entry_t [DEPTH-1:0]       slot_entry
);

    wb_entry_t        storage_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_b_addr;
    logic [1:0]       n_push;

    // When both push, the second entry lands one slot after the first
    assign wr_b_addr = push_a ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    assign n_push    = {1'b0, push_a} + {1'b0, push_b};

    // Entry storage; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (push_a) storage_reg[wr_ptr_reg] <= entry_a;
        if (push_b) storage_reg[wr_b_addr]  <= entry_b;
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(n_push);
            if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg  <= count_reg + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    assign head  = storage_reg[rd_ptr_reg];
    assign count = count_reg;

    // Age 0 is the head (oldest); a slot is live when its age is below count
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_age[gi]   = PTR_W'(gi) - rd_ptr_reg;
        assign slot_valid[gi] = ({1'b0, slot_age[gi]} < count_reg);
        assign slot_entry[gi] = storage_reg[gi];
    end

endmodule

// File: rtl/writeback_stage.sv
// Register-file write-back stage: accepts memory and ALU results, drains one
// per cycle into the register file port, and forwards pending values to decode.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    writeback_stage_if.slave wb
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            free;
    wb_entry_t                   head;
    logic [DEPTH-1:0]            slot_valid;
    logic [DEPTH-1:0][PTR_W-1:0] slot_age;
    wb_entry_t [DEPTH-1:0]       slot_entry;
    logic                        push_mem;
    logic                        push_alu;
    logic                        pop;

    logic                        rf_enable_reg;
    logic [ADDR_W-1:0]           rf_idx_reg;
    logic [DATA_W-1:0]           rf_data_reg;

    logic [ADDR_W-1:0]           fwd_idx   [2];
    logic                        fwd_hit   [2];
    logic [DATA_W-1:0]           fwd_data  [2];
    logic                        fwd_fifo  [2];
    logic [PTR_W-1:0]            fwd_age   [2];

    // Room is judged on occupancy before this cycle's pop; the ALU result
    // only gets in alongside a load when two slots are free
    assign free         = DEPTH_C - count;
    assign wb.mem_ready = (free >= CNT_W'(1));
    assign wb.alu_ready = wb.mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));
    assign push_mem     = wb.mem_valid & wb.mem_ready;
    assign push_alu     = wb.alu_valid & wb.alu_ready;
    assign pop          = (count != '0) && !wb.wb_hold;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_a     (push_mem),
        .entry_a    ('{rd: wb.mem_reg, data: wb.mem_data}),
        .push_b     (push_alu),
        .entry_b    ('{rd: wb.alu_reg, data: wb.alu_data}),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .slot_valid (slot_valid),
        .slot_age   (slot_age),
        .slot_entry (slot_entry)
    );

    // Register-file port register: strobe one head entry per cycle, hold last value otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_enable_reg <= 1'b0;
            rf_idx_reg    <= '0;
            rf_data_reg   <= '0;
        end else begin
            rf_enable_reg <= pop;
            if (pop) begin
                rf_idx_reg  <= head.rd;
                rf_data_reg <= head.data;
            end
        end
    end

    assign wb.rf_enable     = rf_enable_reg;
    assign wb.rf_write_reg  = rf_idx_reg;
    assign wb.rf_write_data = rf_data_reg;
    assign wb.wb_empty      = (count == '0) && !rf_enable_reg;

    assign fwd_idx[0] = wb.fwd_reg1;
    assign fwd_idx[1] = wb.fwd_reg2;

    // Forwarding search: the outgoing register is oldest, then the youngest matching FIFO slot wins
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_hit[p]  = 1'b0;
            fwd_data[p] = '0;
            fwd_fifo[p] = 1'b0;
            fwd_age[p]  = '0;
            if (rf_enable_reg && (rf_idx_reg == fwd_idx[p])) begin
                fwd_hit[p]  = 1'b1;
                fwd_data[p] = rf_data_reg;
            end
            for (int s = 0; s < DEPTH; s++) begin
                if (slot_valid[s] && (slot_entry[s].rd == fwd_idx[p]) &&
                    (!fwd_fifo[p] || (slot_age[s] > fwd_age[p]))) begin
                    fwd_fifo[p] = 1'b1;
                    fwd_age[p]  = slot_age[s];
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = slot_entry[s].data;
                end
            end
        end
    end

    assign wb.fwd_hit1  = fwd_hit[0];
    assign wb.fwd_data1 = fwd_data[0];
    assign wb.fwd_hit2  = fwd_hit[1];
    assign wb.fwd_data2 = fwd_data[1];

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    writeback_stage_if bus ();

    writeback_stage #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    // Reference model: pending writes in arrival order plus the register-file port
    wb_entry_t         mq [$];
    logic              m_en;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_data;

    function automatic int m_free();
        return DEPTH - mq.size();
    endfunction

    function automatic logic m_mem_ready();
        return m_free() >= 1;
    endfunction

    function automatic logic m_alu_ready(input logic mv);
        return mv ? (m_free() >= 2) : (m_free() >= 1);
    endfunction

    // Latest pending write to idx wins; the port register is the oldest candidate
    function automatic void m_fwd(input logic [ADDR_W-1:0] idx, output logic hit,
                                  output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (m_en && m_reg == idx) begin
            hit = 1'b1;
            d   = m_data;
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].rd == idx) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
    endfunction

    function automatic void m_clear();
        mq.delete();
        m_en   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endfunction

    // Advance model and DUT by one clock with the currently driven inputs
    task automatic tick();
        logic am, aa, pp;
        wb_entry_t e;
        am = bus.mem_valid && m_mem_ready();
        aa = bus.alu_valid && m_alu_ready(bus.mem_valid);
        pp = (mq.size() > 0) && !bus.wb_hold;
        if (pp) begin
            e      = mq.pop_front();
            m_reg  = e.rd;
            m_data = e.data;
        end
        m_en = pp;
        if (am) mq.push_back('{rd: bus.mem_reg, data: bus.mem_data});
        if (aa) mq.push_back('{rd: bus.alu_reg, data: bus.alu_data});
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.wb_hold   = 1'b0;
        bus.fwd_reg1  = '0;
        bus.fwd_reg2  = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.rf_enable !== 1'b0 || bus.rf_write_reg !== 4'h0 || bus.rf_write_data !== 16'h0 || bus.wb_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: en=%b reg=%h data=%h empty=%b required 0/0/0000/1",
                     bus.rf_enable, bus.rf_write_reg, bus.rf_write_data, bus.wb_empty);
        end
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd3;
        bus.alu_data  = 16'h1234;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_alu_ready: got %b required 1", bus.alu_ready);
        end
        tick();
        bus.alu_valid = 1'b0;
        checks++;
        if (bus.rf_enable !== 1'b0) begin
            failures++;
            $display("FAIL latency_edge0: rf_enable got %b required 0", bus.rf_enable);
        end
        tick();
        checks++;
        if (bus.rf_enable !== 1'b1 || bus.rf_write_reg !== 4'd3 || bus.rf_write_data !== 16'h1234) begin
            failures++;
            $display("FAIL latency_edge1: en=%b reg=%h data=%h required 1/3/1234",
                     bus.rf_enable, bus.rf_write_reg, bus.rf_write_data);
        end
        tick();
        checks++;
        if (bus.rf_enable !== 1'b0 || bus.wb_empty !== 1'b1 || bus.rf_write_data !== 16'h1234) begin
            failures++;
            $display("FAIL latency_edge2: en=%b empty=%b data=%h required 0/1/1234",
                     bus.rf_enable, bus.wb_empty, bus.rf_write_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_dual_push();
        logic [ADDR_W-1:0] er [2] = '{4'd1, 4'd2};
        logic [DATA_W-1:0] ed [2] = '{16'hAAAA, 16'h5555};
        bus.mem_valid = 1'b1; bus.mem_reg = 4'd1; bus.mem_data = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd2; bus.alu_data = 16'h5555;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL dual_ready: mem=%b alu=%b required 1/1", bus.mem_ready, bus.alu_ready);
        end
        tick();
        drive_idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.rf_enable !== 1'b1 || bus.rf_write_reg !== er[i] || bus.rf_write_data !== ed[i]) begin
                failures++;
                $display("FAIL dual_order%0d: en=%b reg=%h data=%h required 1/%h/%h",
                         i, bus.rf_enable, bus.rf_write_reg, bus.rf_write_data, er[i], ed[i]);
            end
            tick();
        end
        $display("test_dual_push done");
    endtask

    task automatic test_hold_fill();
        logic [DATA_W-1:0] ed [4];
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ed[i]         = 16'($urandom);
            bus.alu_valid = 1'b1;
            bus.alu_reg   = 4'(i + 8);
            bus.alu_data  = ed[i];
            tick();
        end
        bus.alu_data = 16'hDEAD;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.rf_enable !== 1'b0 || bus.wb_empty !== 1'b0) begin
            failures++;
            $display("FAIL hold_full: alu_rdy=%b mem_rdy=%b en=%b empty=%b required 0/0/0/0",
                     bus.alu_ready, bus.mem_ready, bus.rf_enable, bus.wb_empty);
        end
        tick();
        bus.alu_valid = 1'b0;
        bus.wb_hold   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rf_enable !== 1'b1 || bus.rf_write_reg !== 4'(i + 8) || bus.rf_write_data !== ed[i]) begin
                failures++;
                $display("FAIL hold_drain%0d: en=%b reg=%h data=%h required 1/%h/%h",
                         i, bus.rf_enable, bus.rf_write_reg, bus.rf_write_data, 4'(i + 8), ed[i]);
            end
        end
        tick();
        checks++;
        if (bus.wb_empty !== 1'b1) begin
            failures++;
            $display("FAIL hold_empty: got %b required 1", bus.wb_empty);
        end
        $display("test_hold_fill done");
    endtask

    task automatic test_forwarding();
        logic              eh;
        logic [DATA_W-1:0] ed;
        bus.wb_hold   = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd5;
        bus.alu_data  = 16'h0001;
        tick();
        bus.alu_data  = 16'h0002;
        tick();
        bus.alu_valid = 1'b0;
        bus.fwd_reg1  = 4'd5;
        bus.fwd_reg2  = 4'd6;
        #1;
        checks++;
        if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== 16'h0002) begin
            failures++;
            $display("FAIL fwd_youngest: hit=%b data=%h required 1/0002", bus.fwd_hit1, bus.fwd_data1);
        end
        checks++;
        if (bus.fwd_hit2 !== 1'b0 || bus.fwd_data2 !== 16'h0000) begin
            failures++;
            $display("FAIL fwd_miss: hit=%b data=%h required 0/0000", bus.fwd_hit2, bus.fwd_data2);
        end
        bus.wb_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            m_fwd(bus.fwd_reg1, eh, ed);
            checks++;
            if (bus.fwd_hit1 !== eh || bus.fwd_data1 !== ed) begin
                failures++;
                $display("FAIL fwd_drain%0d: hit=%b data=%h required %b/%h", i, bus.fwd_hit1, bus.fwd_data1, eh, ed);
            end
        end
        drive_idle();
        $display("test_forwarding done");
    endtask

    task automatic test_ready_wrap();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_reg   = 4'($urandom_range(0, 15));
            bus.alu_data  = 16'($urandom);
            tick();
        end
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 4'd7;
        bus.mem_data  = 16'hBEEF;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_count3: mem=%b alu=%b required 1/0", bus.mem_ready, bus.alu_ready);
        end
        tick();
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.wb_hold   = ($urandom_range(0, 3) == 0);
            bus.alu_valid = (i < 10) || ($urandom_range(0, 1) == 0);
            bus.alu_reg   = 4'($urandom_range(0, 15));
            bus.alu_data  = 16'($urandom);
            if (i >= 14) begin
                bus.alu_valid = 1'b0;
                bus.wb_hold   = 1'b0;
            end
            tick();
            checks++;
            if (bus.rf_enable !== m_en || bus.rf_write_reg !== m_reg || bus.rf_write_data !== m_data) begin
                failures++;
                $display("FAIL wrap_cycle%0d: en=%b reg=%h data=%h required %b/%h/%h",
                         i, bus.rf_enable, bus.rf_write_reg, bus.rf_write_data, m_en, m_reg, m_data);
            end
        end
        checks++;
        if (bus.wb_empty !== 1'b1 || mq.size() != 0) begin
            failures++;
            $display("FAIL wrap_empty: empty=%b model_pending=%0d required 1/0", bus.wb_empty, mq.size());
        end
        drive_idle();
        $display("test_ready_wrap done");
    endtask

    task automatic test_async_reset();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_reg   = 4'(i);
            bus.alu_data  = 16'($urandom);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.wb_hold   = 1'b0;
        tick();
        bus.fwd_reg1 = 4'd2;
        bus.fwd_reg2 = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_enable !== 1'b0 || bus.wb_empty !== 1'b1 || bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: en=%b empty=%b hit1=%b hit2=%b required 0/1/0/0",
                     bus.rf_enable, bus.wb_empty, bus.fwd_hit1, bus.fwd_hit2);
        end
        m_clear();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rf_enable !== 1'b0 || bus.wb_empty !== 1'b1 || bus.rf_write_data !== 16'h0) begin
            failures++;
            $display("FAIL post_reset: en=%b empty=%b data=%h required 0/1/0000",
                     bus.rf_enable, bus.wb_empty, bus.rf_write_data);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic              eh1, eh2;
        logic [DATA_W-1:0] ed1, ed2;
        for (int i = 0; i < 400; i++) begin
            bus.mem_valid = ($urandom_range(0, 1) == 1);
            bus.mem_reg   = 4'($urandom_range(0, 3));
            bus.mem_data  = 16'($urandom);
            bus.alu_valid = ($urandom_range(0, 1) == 1);
            bus.alu_reg   = 4'($urandom_range(0, 3));
            bus.alu_data  = 16'($urandom);
            bus.wb_hold   = ($urandom_range(0, 2) == 0);
            bus.fwd_reg1  = 4'($urandom_range(0, 4));
            bus.fwd_reg2  = 4'($urandom_range(0, 4));
            #1;
            m_fwd(bus.fwd_reg1, eh1, ed1);
            m_fwd(bus.fwd_reg2, eh2, ed2);
            checks++;
            if (bus.mem_ready !== m_mem_ready() || bus.alu_ready !== m_alu_ready(bus.mem_valid)) begin
                failures++;
                $display("FAIL rnd_ready%0d: mem=%b alu=%b required %b/%b",
                         i, bus.mem_ready, bus.alu_ready, m_mem_ready(), m_alu_ready(bus.mem_valid));
            end
            checks++;
            if (bus.fwd_hit1 !== eh1 || bus.fwd_data1 !== ed1 || bus.fwd_hit2 !== eh2 || bus.fwd_data2 !== ed2) begin
                failures++;
                $display("FAIL rnd_fwd%0d: %b/%h %b/%h required %b/%h %b/%h", i,
                         bus.fwd_hit1, bus.fwd_data1, bus.fwd_hit2, bus.fwd_data2, eh1, ed1, eh2, ed2);
            end
            tick();
            checks++;
            if (bus.rf_enable !== m_en || bus.rf_write_reg !== m_reg || bus.rf_write_data !== m_data ||
                bus.wb_empty !== (mq.size() == 0 && !m_en)) begin
                failures++;
                $display("FAIL rnd_rf%0d: en=%b reg=%h data=%h empty=%b required %b/%h/%h/%b", i,
                         bus.rf_enable, bus.rf_write_reg, bus.rf_write_data, bus.wb_empty,
                         m_en, m_reg, m_data, (mq.size() == 0 && !m_en));
            end
        end
        drive_idle();
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();
        m_clear();
        #2;
        test_reset();
        test_dual_push();
        test_hold_fill();
        test_forwarding();
        test_ready_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
